fetch_stage: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the program counter (PCF), drives the instruction-memory request handshake and loads the IF/ID pipeline register (InstrD, PCD, PC4D, validD). It consumes the redirect signals produced by the ID-stage branch/jump unit. Branches and jumps have one architectural delay slot, so redirects never flush IF/ID.

---
 rtl/fetch_stage.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : MIPS IF stage - PC, imem request handshake, IF/ID register
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        pc_branch,
   input  logic [31:0] B_addr,
   input  logic        jump,
   input  logic [31:0] J_addr,
   input  logic        jump_reg,
   input  logic [31:0] JR_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PCF,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PC4D,
   output logic        validD
);

   typedef enum logic [0:0] {
      S_FETCH = 1'b0,
      S_HOLD  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pcf_q, pcf_d;
   logic [31:0] ibuf_q, ibuf_d;
   logic        pend_valid_q, pend_valid_d;
   logic [31:0] pend_addr_q, pend_addr_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pcd_q, pcd_d;
   logic [31:0] pc4d_q, pc4d_d;
   logic        valid_q, valid_d;

   logic [31:0] pc_plus4;
   logic [31:0] target_sel;
   logic [31:0] target;
   logic [31:0] issue_instr;
   logic        redir;
   logic        issue;

   always_comb begin
      pc_plus4 = pcf_q + 32'd4;

      if (jump_reg)
         target_sel = JR_addr;
      else if (jump)
         target_sel = J_addr;
      else
         target_sel = B_addr;
      target = target_sel & ~32'h3;

      redir = valid_q & ~stall & (jump_reg | jump | pc_branch);
      issue = ~stall & (((state_q == S_FETCH) & imem_ready) | (state_q == S_HOLD));
      issue_instr = (state_q == S_HOLD) ? ibuf_q : imem_rdata;

      state_d      = state_q;
      pcf_d        = pcf_q;
      ibuf_d       = ibuf_q;
      pend_valid_d = pend_valid_q;
      pend_addr_d  = pend_addr_q;
      instr_d      = instr_q;
      pcd_d        = pcd_q;
      pc4d_d       = pc4d_q;
      valid_d      = valid_q;

      if (issue) begin
         instr_d = issue_instr;
         pcd_d   = pcf_q;
         pc4d_d  = pc_plus4;
         valid_d = 1'b1;
         state_d = S_FETCH;
         // A pending redirect belongs to the delay slot issuing now.
         if (pend_valid_q) begin
            pcf_d        = pend_addr_q;
            pend_valid_d = 1'b0;
         end else if (redir) begin
            pcf_d = target;
         end else begin
            pcf_d = pc_plus4;
         end
      end else begin
         if (state_q == S_FETCH) begin
            if (imem_ready && stall) begin
               ibuf_d  = imem_rdata;
               state_d = S_HOLD;
            end else if (!imem_ready && !stall) begin
               valid_d = 1'b0;
               instr_d = 32'd0;
            end
         end
         if (redir && !pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = target;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_FETCH;
         pcf_q        <= RESET_PC;
         ibuf_q       <= 32'd0;
         pend_valid_q <= 1'b0;
         pend_addr_q  <= 32'd0;
         instr_q      <= 32'd0;
         pcd_q        <= 32'd0;
         pc4d_q       <= 32'd0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pcf_q        <= pcf_d;
         ibuf_q       <= ibuf_d;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         instr_q      <= instr_d;
         pcd_q        <= pcd_d;
         pc4d_q       <= pc4d_d;
         valid_q      <= valid_d;
      end
   end

   assign imem_req  = (state_q == S_FETCH) & ~reset;
   assign imem_addr = pcf_q;
   assign PCF       = pcf_q;
   assign InstrD    = instr_q;
   assign PCD       = pcd_q;
   assign PC4D      = pc4d_q;
   assign validD    = valid_q;

endmodule

`default_nettype wire
